// File: rtl/fmap_pkg.sv
// Shared definitions for the feature-map loader, the strided X-interleaved buffer
// and the downstream compute controller.
package fmap_pkg;
    localparam int DATA_WIDTH = 64;
    localparam int B_DSHAPE = 48;
    localparam int B_COORD = 8;
    localparam int B_BEATS = 3 * B_COORD;

    localparam int C_LSB = 0;
    localparam int H_LSB = 16;
    localparam int W_LSB = 32;
    localparam int NWRAP_SHIFT = 6;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_SHAPE = 2'd1;
    localparam logic [1:0] ERR_EARLY_LAST = 2'd2;
    localparam logic [1:0] ERR_MISSING_LAST = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CALC,
        ST_CLR,
        ST_GAP,
        ST_LOAD,
        ST_FLUSH1,
        ST_FLUSH2,
        ST_START,
        ST_ERR
    } state_t;

    // Number of 64-channel wraps; the buffer derives its own copy with this same function.
    function automatic logic [B_COORD-1:0] n_wrap_c_of(input logic [15:NWRAP_SHIFT] c_hi);
        return c_hi[NWRAP_SHIFT +: B_COORD];
    endfunction
endpackage

// File: rtl/fmap_shape_check.sv
// Descriptor validation and registered total-beat product (n_wrap_c * h * w).
module fmap_shape_check
    import fmap_pkg::*;
(
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   calc_en,
    input  logic [15:NWRAP_SHIFT]  c_hi,
    input  logic [15:0]            h,
    input  logic [15:0]            w,
    output logic                   bad_shape,
    output logic [B_BEATS-1:0]     total
);
    logic [B_COORD-1:0] n_wrap_c;
    logic [B_BEATS-1:0] total_d;
    logic [B_BEATS-1:0] total_q;

    always_comb begin
        n_wrap_c = n_wrap_c_of(c_hi);
        bad_shape = (n_wrap_c == '0) || (h == '0) || (w == '0)
                 || (c_hi[15:NWRAP_SHIFT+B_COORD] != '0)
                 || (h[15:B_COORD] != '0) || (w[15:B_COORD] != '0);
        total_d = total_q;
        if (calc_en && !bad_shape) begin
            total_d = B_BEATS'(n_wrap_c) * B_BEATS'(h[B_COORD-1:0]) * B_BEATS'(w[B_COORD-1:0]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    assign total = total_q;
endmodule

// File: rtl/fmap_stream_loader.sv
// Converts a shape descriptor plus an AXI4-Stream of DDR beats into the strided
// buffer's clear / write / start sequence, length-checking the stream against the shape.
module fmap_stream_loader
    import fmap_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [B_DSHAPE-1:0]   cfg_dshape,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [B_DSHAPE-1:0]   buf_dshape,
    output logic                  buf_clr,
    output logic                  buf_we,
    output logic [DATA_WIDTH-1:0] buf_di,
    output logic                  buf_start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [B_BEATS-1:0]    beat_cnt,
    output logic [3:0]            dbg_state
);
    localparam logic [B_BEATS-1:0] ONE = B_BEATS'(1);

    state_t                state_q, state_d;
    logic [B_DSHAPE-1:0]   dshape_q, dshape_d;
    logic [B_BEATS-1:0]    beat_cnt_q, beat_cnt_d;
    logic                  err_q, err_d;
    logic [1:0]            err_code_q, err_code_d;
    logic                  buf_we_q, buf_we_d;
    logic [DATA_WIDTH-1:0] buf_di_q, buf_di_d;
    logic                  buf_clr_q, buf_clr_d;
    logic                  buf_start_q, buf_start_d;
    logic                  done_q, done_d;
    logic                  tready_q, tready_d;
    logic                  cfg_ready_q, cfg_ready_d;
    logic                  busy_q, busy_d;

    logic                  calc_en;
    logic                  bad_shape;
    logic [B_BEATS-1:0]    total;
    logic                  hs;
    logic                  last_beat;

    fmap_shape_check u_shape_check (
        .clk       (clk),
        .rstn      (rstn),
        .calc_en   (calc_en),
        .c_hi      (dshape_q[C_LSB+NWRAP_SHIFT +: 16-NWRAP_SHIFT]),
        .h         (dshape_q[H_LSB +: 16]),
        .w         (dshape_q[W_LSB +: 16]),
        .bad_shape (bad_shape),
        .total     (total)
    );

    // A transfer happens on any edge where both valid and ready are high; a
    // valid source holds its payload until that edge, and ready never waits on valid.
    assign hs = tready_q && s_axis_tvalid;
    assign last_beat = (beat_cnt_q + ONE) == total;

    always_comb begin
        state_d = state_q;
        dshape_d = dshape_q;
        beat_cnt_d = beat_cnt_q;
        err_d = err_q;
        err_code_d = err_code_q;
        buf_we_d = 1'b0;
        buf_di_d = buf_di_q;
        calc_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    dshape_d = cfg_dshape;
                    err_d = 1'b0;
                    err_code_d = ERR_NONE;
                    beat_cnt_d = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                calc_en = 1'b1;
                if (bad_shape) begin
                    err_d = 1'b1;
                    err_code_d = ERR_SHAPE;
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_CLR;
                end
            end
            ST_CLR:    state_d = ST_GAP;
            ST_GAP:    state_d = ST_LOAD;
            ST_LOAD: begin
                if (hs) begin
                    // The offending beat is still written so the buffer sees the raw stream.
                    buf_we_d = 1'b1;
                    buf_di_d = s_axis_tdata;
                    beat_cnt_d = beat_cnt_q + ONE;
                    if (s_axis_tlast && !last_beat) begin
                        err_d = 1'b1;
                        err_code_d = ERR_EARLY_LAST;
                        state_d = ST_ERR;
                    end else if (last_beat && !s_axis_tlast) begin
                        err_d = 1'b1;
                        err_code_d = ERR_MISSING_LAST;
                        state_d = ST_ERR;
                    end else if (last_beat) begin
                        state_d = ST_FLUSH1;
                    end
                end
            end
            ST_FLUSH1: state_d = ST_FLUSH2;
            ST_FLUSH2: state_d = ST_START;
            ST_START:  state_d = ST_IDLE;
            ST_ERR:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        buf_clr_d = (state_d == ST_CLR);
        buf_start_d = (state_d == ST_START);
        done_d = (state_d == ST_START);
        tready_d = (state_d == ST_LOAD);
        cfg_ready_d = (state_d == ST_IDLE);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            dshape_q <= '0;
            beat_cnt_q <= '0;
            err_q <= 1'b0;
            err_code_q <= ERR_NONE;
            buf_we_q <= 1'b0;
            buf_di_q <= '0;
            buf_clr_q <= 1'b0;
            buf_start_q <= 1'b0;
            done_q <= 1'b0;
            tready_q <= 1'b0;
            cfg_ready_q <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dshape_q <= dshape_d;
            beat_cnt_q <= beat_cnt_d;
            err_q <= err_d;
            err_code_q <= err_code_d;
            buf_we_q <= buf_we_d;
            buf_di_q <= buf_di_d;
            buf_clr_q <= buf_clr_d;
            buf_start_q <= buf_start_d;
            done_q <= done_d;
            tready_q <= tready_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q <= busy_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign s_axis_tready = tready_q;
    assign buf_dshape = dshape_q;
    assign buf_clr = buf_clr_q;
    assign buf_we = buf_we_q;
    assign buf_di = buf_di_q;
    assign buf_start = buf_start_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err = err_q;
    assign err_code = err_code_q;
    assign beat_cnt = beat_cnt_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_fmap_stream_loader.sv
// Scoreboarded bench for fmap_stream_loader: driver pushes expected buffer writes,
// a negedge monitor pops and compares them and timestamps the control pulses.
module tb_fmap_stream_loader;
  import fmap_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic [47:0] cfg_dshape = '0;
  logic [63:0] s_axis_tdata = '0;
  logic s_axis_tvalid = 1'b0;
  logic s_axis_tready;
  logic s_axis_tlast = 1'b0;
  logic [47:0] buf_dshape;
  logic buf_clr, buf_we, buf_start, busy, done, err;
  logic [63:0] buf_di;
  logic [1:0] err_code;
  logic [23:0] beat_cnt;
  logic [3:0] dbg_state;

  fmap_stream_loader dut (
    .clk(clk), .rstn(rstn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_dshape(cfg_dshape), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .buf_dshape(buf_dshape),
    .buf_clr(buf_clr), .buf_we(buf_we), .buf_di(buf_di), .buf_start(buf_start),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .beat_cnt(beat_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];
  logic [63:0] pattern[64];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  int we_total = 0, clr_total = 0, start_total = 0, done_total = 0, tready_total = 0;
  int first_we_cyc = 0, last_we_cyc = 0, clr_cyc = 0, start_cyc = 0, done_cyc = 0;
  int tready_rise_cyc = 0, tready_fall_cyc = 0, err_rise_cyc = 0, cfg_ready_rise_cyc = 0;
  logic prev_we = 1'b0, prev_tready = 1'b0, prev_err = 1'b0, prev_cfg_ready = 1'b1;

  always @(negedge clk) begin
    if (rstn) begin
      if (buf_we) begin
        we_total++;
        if (!prev_we) first_we_cyc = cyc;
        last_we_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_write", 64'd1, 64'd0);
        else check("buf_di", buf_di, exp_q.pop_front());
      end
      if (buf_clr) begin clr_total++; clr_cyc = cyc; end
      if (buf_start) begin start_total++; start_cyc = cyc; end
      if (done) begin done_total++; done_cyc = cyc; end
      if (s_axis_tready) tready_total++;
      if (s_axis_tready && !prev_tready) tready_rise_cyc = cyc;
      if (!s_axis_tready && prev_tready) tready_fall_cyc = cyc;
      if (err && !prev_err) err_rise_cyc = cyc;
      if (cfg_ready && !prev_cfg_ready) cfg_ready_rise_cyc = cyc;
    end
    prev_we = buf_we;
    prev_tready = s_axis_tready;
    prev_err = err;
    prev_cfg_ready = cfg_ready;
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {cfg_ready, s_axis_tready, buf_clr, buf_we, buf_start, busy, done, err, err_code},
          {1'b1, 9'b0});
    check({tag, "_beat_cnt"}, 64'(beat_cnt), 64'd0);
    check({tag, "_buf_di"}, buf_di, 64'd0);
    check({tag, "_dshape"}, 64'(buf_dshape), 64'd0);
  endtask

  task automatic wait_idle(input string tag);
    int guard = 0;
    while (!cfg_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    if (!cfg_ready) check({tag, "_idle_timeout"}, 64'd0, 64'd1);
    @(negedge clk); #1;
  endtask

  // mode: n_send beats offered, tlast on beat last_at (0 = never), rst_at aborts before that beat.
  task automatic run_load(input string tag, input logic [15:0] c, input logic [15:0] h,
                          input logic [15:0] w, input int n_send, input int last_at,
                          input bit rand_valid, input int rst_at);
    logic [47:0] d;
    int nw, total, exp_writes, exp_code, acc, hs_cyc, k, guard;
    int we0, clr0, start0, done0, tr0;
    bit bad, hs;
    d = {w, h, c};
    // reference model from the descriptor rules and stream length rules
    nw = (int'(c) >> 6) & 255;
    bad = (nw == 0) || (h == 0) || (w == 0) || (c >= 16'd16384) || (h >= 16'd256) || (w >= 16'd256);
    total = nw * int'(h) * int'(w);
    exp_writes = 0;
    exp_code = 0;
    if (bad) exp_code = 1;
    else begin
      for (int i = 1; i <= n_send; i++) begin
        exp_writes = i;
        if (i == last_at && i != total) begin exp_code = 2; break; end
        if (i == total && last_at != i) begin exp_code = 3; break; end
        if (i == total) break;
      end
    end
    we0 = we_total; clr0 = clr_total; start0 = start_total; done0 = done_total; tr0 = tready_total;

    wait_idle({tag, "_pre"});
    cfg_dshape = d;
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    acc = cyc;
    check({tag, "_calc_err"}, {err, err_code}, 3'b000);
    check({tag, "_calc_beat_cnt"}, 64'(beat_cnt), 64'd0);
    check({tag, "_calc_busy"}, {busy, cfg_ready}, 2'b10);
    check({tag, "_dshape"}, 64'(buf_dshape), 64'(d));

    hs_cyc = acc;
    if (!bad) begin
      k = 0;
      guard = 0;
      while (k < exp_writes && guard < 2000) begin
        s_axis_tvalid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        s_axis_tdata = pattern[k];
        s_axis_tlast = (k + 1 == last_at);
        if (rand_valid) begin
          cfg_valid = 1'($urandom_range(0, 1));
          cfg_dshape = {16'($urandom), $urandom};
        end
        if (rst_at != 0 && k == rst_at - 1) begin
          @(negedge clk); #2;
          rstn = 1'b0;
          #1;
          check_reset_outputs({tag, "_midrst"});
          exp_q.delete();
          s_axis_tvalid = 1'b0;
          s_axis_tlast = 1'b0;
          @(posedge clk); #1;
          rstn = 1'b1;
          return;
        end
        @(negedge clk);
        hs = s_axis_tready && s_axis_tvalid;
        if (hs) begin
          exp_q.push_back(pattern[k]);
          hs_cyc = cyc;
          k++;
        end
        @(posedge clk); #1;
        guard++;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0;
      cfg_valid = 1'b0;
      if (k < exp_writes) check({tag, "_beats_timeout"}, 64'(k), 64'(exp_writes));
    end
    wait_idle({tag, "_post"});

    check({tag, "_writes"}, 64'(we_total - we0), 64'(exp_writes));
    check({tag, "_exp_q_empty"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_beat_cnt"}, 64'(beat_cnt), 64'(exp_writes));
    check({tag, "_err"}, {err, err_code}, {exp_code != 0, 2'(exp_code)});
    check({tag, "_dshape_held"}, 64'(buf_dshape), 64'(d));
    check({tag, "_starts"}, 64'(start_total - start0), (exp_code == 0) ? 64'd1 : 64'd0);
    if (bad) begin
      check({tag, "_clr_count"}, 64'(clr_total - clr0), 64'd0);
      check({tag, "_tready_count"}, 64'(tready_total - tr0), 64'd0);
      check({tag, "_err_rise"}, 64'(err_rise_cyc), 64'(acc + 1));
      check({tag, "_cfg_ready_rise"}, 64'(cfg_ready_rise_cyc), 64'(acc + 2));
    end else begin
      check({tag, "_clr_count"}, 64'(clr_total - clr0), 64'd1);
      check({tag, "_clr_cyc"}, 64'(clr_cyc), 64'(acc + 1));
      check({tag, "_tready_rise"}, 64'(tready_rise_cyc), 64'(acc + 3));
      check({tag, "_tready_fall"}, 64'(tready_fall_cyc), 64'(hs_cyc + 1));
      check({tag, "_last_we"}, 64'(last_we_cyc), 64'(hs_cyc + 1));
      if (exp_code == 0) begin
        check({tag, "_done_count"}, 64'(done_total - done0), 64'd1);
        check({tag, "_start_lat"}, 64'(start_cyc), 64'(last_we_cyc + 2));
        check({tag, "_done_cyc"}, 64'(done_cyc), 64'(start_cyc));
        check({tag, "_cfg_ready_rise"}, 64'(cfg_ready_rise_cyc), 64'(start_cyc + 1));
        if (!rand_valid) check({tag, "_back_to_back"}, 64'(last_we_cyc - first_we_cyc), 64'(exp_writes - 1));
      end else begin
        check({tag, "_err_rise"}, 64'(err_rise_cyc), 64'(hs_cyc + 1));
        check({tag, "_cfg_ready_rise"}, 64'(cfg_ready_rise_cyc), 64'(hs_cyc + 2));
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nwr, hh, ww, tot, mode;
    for (int i = 0; i < 64; i++) pattern[i] = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rstn = 1'b1;
    @(posedge clk); #1;

    run_load("full40", 16'd128, 16'd4, 16'd5, 40, 40, 1'b0, 0);
    run_load("rand40", 16'd128, 16'd4, 16'd5, 40, 40, 1'b1, 0);
    run_load("early", 16'd64, 16'd2, 16'd3, 6, 4, 1'b0, 0);
    run_load("missing", 16'd64, 16'd2, 16'd3, 6, 0, 1'b0, 0);
    run_load("nwrap0", 16'd32, 16'd4, 16'd5, 0, 0, 1'b0, 0);
    run_load("h256", 16'd128, 16'd256, 16'd5, 0, 0, 1'b0, 0);
    run_load("rst", 16'd128, 16'd4, 16'd5, 40, 40, 1'b0, 10);
    run_load("full40b", 16'd128, 16'd4, 16'd5, 40, 40, 1'b0, 0);

    for (int r = 0; r < 6; r++) begin
      nwr = $urandom_range(1, 2);
      hh = $urandom_range(1, 3);
      ww = $urandom_range(1, 4);
      tot = nwr * hh * ww;
      mode = $urandom_range(0, 2);
      if (mode == 1 && tot >= 2)
        run_load("rnd_early", 16'(nwr << 6), 16'(hh), 16'(ww), tot, $urandom_range(1, tot - 1), 1'b1, 0);
      else if (mode == 2)
        run_load("rnd_missing", 16'(nwr << 6), 16'(hh), 16'(ww), tot, 0, 1'b1, 0);
      else
        run_load("rnd_ok", 16'(nwr << 6), 16'(hh), 16'(ww), tot, tot, 1'b1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
